// File: rtl/i2c_reg_sequencer.sv
// rtl/i2c_reg_sequencer.sv - register-access command sequencer for the i2c_master byte engine (optional I2C_SEQ_TIMEOUT_EN)
module i2c_reg_sequencer #(
    parameter logic SPEED_400K     = 1'b0,
    parameter int   TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rnw,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       rsp_timeout,
    output logic       m_cs,
    output logic       m_wr,
    output logic       m_rd,
    output logic [2:0] m_addr,
    output logic [7:0] m_wdata,
    input  logic [7:0] m_rdata
);

    typedef enum logic [2:0] {
        S_INIT,
        S_SPEED,
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_POLL,
        S_FETCH,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        K_START,
        K_WB,
        K_RD,
        K_FETCH,
        K_STOP
    } kind_t;

    localparam logic [2:0] A_START  = 3'd0;
    localparam logic [2:0] A_STOP   = 3'd1;
    localparam logic [2:0] A_READ   = 3'd2;
    localparam logic [2:0] A_DATA   = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;

    state_t     state, state_nx;
    logic [2:0] step, step_nx;
    logic       rnw_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q;
    logic [7:0] wdata_q;

    kind_t      kind;
    logic [7:0] step_byte;
    logic [2:0] stop_step;
    logic [2:0] op_addr;
    logic [7:0] op_wdata;

    logic       accept;
    logic       cap_rdata;
    logic       set_nack;
    logic       set_timeout;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam logic [15:0] T_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tcnt;
`endif

    // Step list decode: what the current step index means for the latched command
    always_comb begin
        kind      = K_STOP;
        step_byte = 8'h00;
        if (!rnw_q) begin
            case (step)
                3'd0:    kind = K_START;
                3'd1:    begin kind = K_WB; step_byte = {dev_q, 1'b0}; end
                3'd2:    begin kind = K_WB; step_byte = reg_q; end
                3'd3:    begin kind = K_WB; step_byte = wdata_q; end
                default: kind = K_STOP;
            endcase
        end else begin
            case (step)
                3'd0:    kind = K_START;
                3'd1:    begin kind = K_WB; step_byte = {dev_q, 1'b0}; end
                3'd2:    begin kind = K_WB; step_byte = reg_q; end
                3'd3:    kind = K_START;
                3'd4:    begin kind = K_WB; step_byte = {dev_q, 1'b1}; end
                3'd5:    kind = K_RD;
                3'd6:    kind = K_FETCH;
                default: kind = K_STOP;
            endcase
        end
    end

    assign stop_step = rnw_q ? 3'd7 : 3'd4;

    // Engine register write issued for the current step (read issues in_data 0 so the master NACKs the last byte)
    always_comb begin
        op_addr  = A_STOP;
        op_wdata = 8'h01;
        case (kind)
            K_START: begin op_addr = A_START; op_wdata = 8'h01; end
            K_WB:    begin op_addr = A_DATA;  op_wdata = step_byte; end
            K_RD:    begin op_addr = A_READ;  op_wdata = 8'h00; end
            default: begin op_addr = A_STOP;  op_wdata = 8'h01; end
        endcase
    end

    // Next-state and engine strobe generation
    always_comb begin
        state_nx    = state;
        step_nx     = step;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        m_cs        = 1'b0;
        m_wr        = 1'b0;
        m_rd        = 1'b0;
        m_addr      = 3'd0;
        m_wdata     = 8'h00;
        accept      = 1'b0;
        cap_rdata   = 1'b0;
        set_nack    = 1'b0;
        set_timeout = 1'b0;
        case (state)
            S_INIT: state_nx = S_SPEED;
            S_SPEED: begin
                m_cs     = 1'b1;
                m_wr     = 1'b1;
                m_addr   = A_STATUS;
                m_wdata  = {7'b0, SPEED_400K};
                state_nx = S_IDLE;
            end
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept   = 1'b1;
                    step_nx  = 3'd0;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                m_cs     = 1'b1;
                m_wr     = 1'b1;
                m_addr   = op_addr;
                m_wdata  = op_wdata;
                state_nx = S_GAP;
            end
            // Strobes low for one cycle so the engine's busy flag is visible before polling
            S_GAP: state_nx = S_POLL;
            S_POLL: begin
                m_cs   = 1'b1;
                m_rd   = 1'b1;
                m_addr = A_STATUS;
                if (!m_rdata[0]) begin
                    if (kind == K_STOP) begin
                        state_nx = S_DONE;
                    end else if (kind == K_WB && m_rdata[1]) begin
                        set_nack = 1'b1;
                        step_nx  = stop_step;
                        state_nx = S_ISSUE;
                    end else begin
                        step_nx  = step + 3'd1;
                        state_nx = (rnw_q && step == 3'd5) ? S_FETCH : S_ISSUE;
                    end
                end
`ifdef I2C_SEQ_TIMEOUT_EN
                else if (tcnt == T_LIMIT) begin
                    // Engine is wedged; a STOP write would never complete, so report directly
                    set_timeout = 1'b1;
                    state_nx    = S_DONE;
                end
`endif
            end
            S_FETCH: begin
                m_cs      = 1'b1;
                m_rd      = 1'b1;
                m_addr    = A_DATA;
                cap_rdata = 1'b1;
                step_nx   = step + 3'd1;
                state_nx  = S_ISSUE;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_INIT;
        endcase
    end

    // State, step index and latched command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_INIT;
            step    <= 3'd0;
            rnw_q   <= 1'b0;
            dev_q   <= 7'd0;
            reg_q   <= 8'h00;
            wdata_q <= 8'h00;
        end else begin
            state <= state_nx;
            step  <= step_nx;
            if (accept) begin
                rnw_q   <= cmd_rnw;
                dev_q   <= cmd_dev;
                reg_q   <= cmd_reg;
                wdata_q <= cmd_wdata;
            end
        end
    end

    // Response data and NACK status, held between transactions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= 8'h00;
            rsp_nack  <= 1'b0;
        end else begin
            if (cap_rdata) rsp_rdata <= m_rdata;
            if (accept) rsp_nack <= 1'b0;
            else if (set_nack) rsp_nack <= 1'b1;
        end
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    // Poll watchdog: restarts in the GAP before every poll, counts each poll cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt        <= 16'd0;
            rsp_timeout <= 1'b0;
        end else begin
            if (state == S_GAP) tcnt <= 16'd0;
            else if (state == S_POLL) tcnt <= tcnt + 16'd1;
            if (accept) rsp_timeout <= 1'b0;
            else if (set_timeout) rsp_timeout <= 1'b1;
        end
    end
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb/tb_i2c_reg_sequencer.sv - scoreboard bench for i2c_reg_sequencer with engine and slave (7'h48) models
module tb_i2c_reg_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rnw = 1'b0;
    logic [6:0] cmd_dev = 7'd0;
    logic [7:0] cmd_reg = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       rsp_timeout;
    logic       m_cs, m_wr, m_rd;
    logic [2:0] m_addr;
    logic [7:0] m_wdata;
    logic [7:0] m_rdata;

    always #5 clk = ~clk;

    i2c_reg_sequencer #(.SPEED_400K(1'b1), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .rsp_timeout(rsp_timeout),
        .m_cs(m_cs), .m_wr(m_wr), .m_rd(m_rd), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    typedef struct {logic [2:0] addr; logic [7:0] data;} op_t;
    typedef struct {logic nack; logic tmo; logic [7:0] rdata;} rsp_t;

    op_t  exp_ops[$];
    rsp_t exp_rsp[$];
    op_t  mon_op;
    rsp_t mon_rsp;
    int   vectors = 0;
    int   miscompares = 0;
    int   poll_run = 0;
    logic stuck = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Engine + slave model: busy for 3 cycles after each write, slave at 7'h48 with register file
    logic [7:0] sregs [0:255];
    int         busy_cnt;
    logic       sel, rd_mode, ptr_set, last_nack, expect_addr;
    logic [7:0] ptr, rd_reg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= 0; sel <= 0; rd_mode <= 0; ptr_set <= 0;
            last_nack <= 0; expect_addr <= 0; ptr <= 0; rd_reg <= 0;
            for (int i = 0; i < 256; i++) sregs[i] <= 8'h00;
            sregs[2] <= 8'h3C;
        end else begin
            if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
            if (m_cs && m_wr) begin
                busy_cnt <= 3;
                case (m_addr)
                    3'd0: begin expect_addr <= 1; last_nack <= 0; end
                    3'd1: begin sel <= 0; expect_addr <= 0; end
                    3'd2: begin
                        if (sel && rd_mode) begin rd_reg <= sregs[ptr]; ptr <= ptr + 1; end
                        else rd_reg <= 8'hFF;
                        last_nack <= 0;
                    end
                    3'd3: begin
                        if (expect_addr) begin
                            expect_addr <= 0;
                            sel <= (m_wdata[7:1] == 7'h48);
                            rd_mode <= m_wdata[0];
                            ptr_set <= 0;
                            last_nack <= (m_wdata[7:1] != 7'h48);
                        end else if (sel && !rd_mode) begin
                            last_nack <= 0;
                            if (!ptr_set) begin ptr <= m_wdata; ptr_set <= 1; end
                            else begin sregs[ptr] <= m_wdata; ptr <= ptr + 1; end
                        end else begin
                            last_nack <= 1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign m_rdata = (m_addr == 3'd4) ? {4'b0, 1'b1, 1'b0, last_nack, (busy_cnt != 0) || stuck} :
                     (m_addr == 3'd3) ? rd_reg : 8'h00;

    // Monitor: compare engine writes and responses against the scoreboard queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_cs && m_rd && m_addr == 3'd4) poll_run++;
            if (m_cs && m_wr) begin
                if (exp_ops.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_write: got addr %0d data %0h expected none", m_addr, m_wdata);
                end else begin
                    mon_op = exp_ops.pop_front();
                    check("op_addr", 32'(m_addr), 32'(mon_op.addr));
                    check("op_data", 32'(m_wdata), 32'(mon_op.data));
                end
            end
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_rsp: got rsp_valid expected none");
                end else begin
                    mon_rsp = exp_rsp.pop_front();
                    check("rsp_nack", 32'(rsp_nack), 32'(mon_rsp.nack));
                    check("rsp_timeout", 32'(rsp_timeout), 32'(mon_rsp.tmo));
                    check("rsp_rdata", 32'(rsp_rdata), 32'(mon_rsp.rdata));
                end
            end
        end
    end

    task automatic push_op(input logic [2:0] a, input logic [7:0] d);
        op_t o;
        o.addr = a; o.data = d;
        exp_ops.push_back(o);
    endtask

    task automatic push_rsp(input logic n, input logic t, input logic [7:0] r);
        rsp_t x;
        x.nack = n; x.tmo = t; x.rdata = r;
        exp_rsp.push_back(x);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    endtask

    task automatic issue_cmd(input logic rnw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
        wait_ready();
        cmd_rnw = rnw; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic rnw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
        int n;
        issue_cmd(rnw, dev, rg, wd);
        n = 0;
        while (exp_rsp.size() != 0 && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        check("rsp_arrived", 32'(exp_rsp.size()), 32'd0);
        check("ops_consumed", 32'(exp_ops.size()), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        check({tag, "_strobes"}, 32'({m_cs, m_wr, m_rd}), 32'd0);
        check({tag, "_rsp"}, 32'({rsp_valid, rsp_nack, rsp_timeout}), 32'd0);
        check({tag, "_rdata"}, 32'(rsp_rdata), 32'd0);
    endtask

    initial begin
        int n;
        // Reset and speed write
        #3 check_outputs_zero("reset");
        push_op(3'd4, 8'h01);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ready();
        check("speed_written", 32'(exp_ops.size()), 32'd0);

        // Write 48/10 <= A5
        push_op(3'd0, 8'h01); push_op(3'd3, 8'h90); push_op(3'd3, 8'h10);
        push_op(3'd3, 8'hA5); push_op(3'd1, 8'h01);
        push_rsp(1'b0, 1'b0, 8'h00);
        run_cmd(1'b0, 7'h48, 8'h10, 8'hA5);

        // Read 48/02 -> 3C
        push_op(3'd0, 8'h01); push_op(3'd3, 8'h90); push_op(3'd3, 8'h02);
        push_op(3'd0, 8'h01); push_op(3'd3, 8'h91); push_op(3'd2, 8'h00);
        push_op(3'd1, 8'h01);
        push_rsp(1'b0, 1'b0, 8'h3C);
        run_cmd(1'b1, 7'h48, 8'h02, 8'h00);

        // Read from absent 7'h50: address NACK, STOP, rdata unchanged
        push_op(3'd0, 8'h01); push_op(3'd3, 8'hA0); push_op(3'd1, 8'h01);
        push_rsp(1'b1, 1'b0, 8'h3C);
        run_cmd(1'b1, 7'h50, 8'h02, 8'h00);

        // Write 48/05 <= 5A clears nack
        push_op(3'd0, 8'h01); push_op(3'd3, 8'h90); push_op(3'd3, 8'h05);
        push_op(3'd3, 8'h5A); push_op(3'd1, 8'h01);
        push_rsp(1'b0, 1'b0, 8'h3C);
        run_cmd(1'b0, 7'h48, 8'h05, 8'h5A);

        // Read back 48/10 -> A5
        push_op(3'd0, 8'h01); push_op(3'd3, 8'h90); push_op(3'd3, 8'h10);
        push_op(3'd0, 8'h01); push_op(3'd3, 8'h91); push_op(3'd2, 8'h00);
        push_op(3'd1, 8'h01);
        push_rsp(1'b0, 1'b0, 8'hA5);
        run_cmd(1'b1, 7'h48, 8'h10, 8'h00);

        // Write to absent 7'h50
        push_op(3'd0, 8'h01); push_op(3'd3, 8'hA0); push_op(3'd1, 8'h01);
        push_rsp(1'b1, 1'b0, 8'hA5);
        run_cmd(1'b0, 7'h50, 8'h33, 8'h44);

        // Read back 48/05 -> 5A
        push_op(3'd0, 8'h01); push_op(3'd3, 8'h90); push_op(3'd3, 8'h05);
        push_op(3'd0, 8'h01); push_op(3'd3, 8'h91); push_op(3'd2, 8'h00);
        push_op(3'd1, 8'h01);
        push_rsp(1'b0, 1'b0, 8'h5A);
        run_cmd(1'b1, 7'h48, 8'h05, 8'h00);

`ifdef I2C_SEQ_TIMEOUT_EN
        // Stuck bus: START poll expires after 100 cycles, no STOP
        stuck = 1'b1;
        poll_run = 0;
        push_op(3'd0, 8'h01);
        push_rsp(1'b0, 1'b1, 8'h5A);
        run_cmd(1'b0, 7'h48, 8'h01, 8'h02);
        check("timeout_poll_cycles", 32'(poll_run), 32'd100);
        wait_ready();
        stuck = 1'b0;
`endif

        // Reset mid-WB, then INIT speed write again
        push_op(3'd0, 8'h01); push_op(3'd3, 8'h90);
        issue_cmd(1'b0, 7'h48, 8'h20, 8'h77);
        n = 0;
        @(negedge clk);
        while (!(m_cs && m_wr && m_addr == 3'd3) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("reached_wb", 32'(m_cs && m_wr && m_addr == 3'd3), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("midreset");
        exp_ops.delete();
        exp_rsp.delete();
        push_op(3'd4, 8'h01);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ready();
        check("respeed_written", 32'(exp_ops.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected summary");
        $fatal(1, "watchdog expired");
    end

endmodule
